uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, 417, clk cycles per serial bit (48 MHz / 115200 baud); legal range 4..65535.
REQ-002 clk  input  1  single system clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset); name "reset" per codebase, polarity fixed low.
REQ-004 serial_rxd  input  1  asynchronous UART line, idle high, 8N1 format, LSB first.
REQ-005 rx_pop  input  1  one-cycle read strobe from data memory; consumes held byte, clears sticky flags.
REQ-006 rx_data  output  8  last committed byte.
REQ-007 rx_valid  output  1  rx_data holds an unread byte.
REQ-008 rx_overrun  output  1  sticky; byte lost because holding register was full.
REQ-009 rx_frame_err  output  1  sticky; stop bit sampled low.
REQ-010 rx_busy  output  1  high whenever FSM is not IDLE.

Function
REQ-011 serial_rxd SHALL pass through a 2-flop synchronizer (flops reset to 1); FSM uses only synchronized line.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-013 IDLE: synchronized line = 0 -> START, bit counter loaded with CLKS_PER_BIT/2 - 1 (integer division).
REQ-014 START: at counter zero, line = 0 -> DATA with counter CLKS_PER_BIT - 1, bit index 0; line = 1 -> IDLE (glitch rejected, no flags).
REQ-015 DATA: at each counter zero, sample into shift register bit[index], reload counter; after index 7 sampled -> STOP.
REQ-016 STOP: at counter zero, line = 1 -> commit byte, IDLE; line = 0 -> set rx_frame_err, discard byte, BREAK.
REQ-017 BREAK: remain until synchronized line = 1, then IDLE.
REQ-018 Commit with rx_valid = 0: rx_data <= byte, rx_valid <= 1 on next edge.
REQ-019 Commit with rx_valid = 1 and no rx_pop same cycle: new byte discarded, rx_data unchanged, rx_overrun <= 1.
REQ-020 Commit and rx_pop same cycle: rx_data <= new byte, rx_valid stays 1, no overrun.
REQ-021 rx_pop without commit: rx_valid <= 0; rx_data holds value.
REQ-022 rx_pop SHALL clear rx_overrun and rx_frame_err on next edge unless the same cycle sets them (set wins).
REQ-023 Latency: rx_valid rises exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks after serial_rxd falls (±1 synchronizer uncertainty).
REQ-024 Back-to-back frames with zero idle between stop and next start SHALL be received without loss.

Reset
REQ-025 reset = 0 SHALL immediately force: state IDLE, counters 0, shift register 0, rx_data 0x00, rx_valid 0, rx_overrun 0, rx_frame_err 0, rx_busy 0, synchronizer flops 1.
REQ-026 Reset mid-frame SHALL abandon the frame with no flags set; reception resumes at next falling edge after release.

Structure
REQ-027 Package uart_pkg SHALL hold the rx state enum typedef and the CLKS_PER_BIT default constant, shared with the existing serial_txd transmitter.
REQ-028 One sub-module: bit_sync (2-flop synchronizer, parameterized reset value).
REQ-029 Target 120-250 lines of RTL; no FIFO (single holding register).

Verification (CLKS_PER_BIT = 16)
REQ-030 Send 0x55 -> rx_data = 0x55, rx_valid = 1 at cycle per REQ-023, flags 0, rx_busy low afterwards.
REQ-031 Send 0xA3 then 0x0F with no pop -> rx_data = 0xA3, rx_overrun = 1; pulse rx_pop -> rx_valid = 0, rx_overrun = 0.
REQ-032 Hold line low 4 clocks then high -> rx_busy pulses, returns IDLE, rx_valid = 0, no flags.
REQ-033 Send 0xFF with stop bit low, line held low 40 clocks -> rx_frame_err = 1, rx_valid = 0, rx_busy = 1 until line returns high.
REQ-034 Assert reset during bit 4 of 0x3C, release, resend 0x3C -> outputs zeroed during reset, then rx_data = 0x3C, no flags.
REQ-035 Pulse rx_pop on the exact commit cycle of second byte 0x81 -> rx_valid stays 1, rx_data = 0x81, rx_overrun = 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default bit timing,
// used by both the serial_rxd receiver and the serial_txd transmitter.
package uart_pkg;

    // 48 MHz system clock / 115200 baud
    localparam int CLKS_PER_BIT_DEF = 417;

    // Payload width of one 8N1 character
    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-data-memory handshake: held byte, sticky status and read strobe.
interface uart_rx_if;
    import uart_pkg::*;

    logic                 rx_pop;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_overrun;
    logic                 rx_frame_err;
    logic                 rx_busy;

    // Receiver side drives data and status, consumer issues pops
    modport master (
        input  rx_pop,
        output rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy
    );

    modport slave (
        output rx_pop,
        input  rx_data, rx_valid, rx_overrun, rx_frame_err, rx_busy
    );

endinterface

// File: rtl/uart_rx_bit_sync.sv
// Two-flop synchronizer for a single asynchronous input, with a selectable
// reset value so an idle-high line does not look like a start bit after reset.
module bit_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Double-register the asynchronous input to resolve metastability
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a single holding register and
// sticky overrun / framing-error flags cleared by the consumer's pop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      serial_rxd,
    uart_rx_if.master bus
);

    // Counter reload values: half a bit to reach the start-bit centre,
    // then a full bit between successive sample points.
    localparam logic [15:0] HALF_LD = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_LD = 16'(CLKS_PER_BIT - 1);

    logic                 rxd_s;
    rx_state_t            state_q, state_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 cnt_zero;
    logic                 commit;
    logic                 frame_set;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 rx_overrun_q;
    logic                 rx_frame_err_q;

    bit_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (serial_rxd),
        .q     (rxd_s)
    );

    assign cnt_zero = (cnt_q == 16'd0);

    // FSM and bit-timing state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RX_IDLE;
            cnt_q   <= 16'd0;
            idx_q   <= 3'd0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic: count to each sample point, then act on the line value
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        commit    = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rxd_s) begin
                    state_d = RX_START;
                    cnt_d   = HALF_LD;
                end
            end
            RX_START: begin
                if (cnt_zero) begin
                    if (!rxd_s) begin
                        state_d = RX_DATA;
                        cnt_d   = FULL_LD;
                        idx_d   = 3'd0;
                    end else begin
                        // Line went back high before mid-start: treat as noise
                        state_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_DATA: begin
                if (cnt_zero) begin
                    shift_d[idx_q] = rxd_s;
                    cnt_d          = FULL_LD;
                    if (idx_q == 3'd7) begin
                        state_d = RX_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_STOP: begin
                if (cnt_zero) begin
                    if (rxd_s) begin
                        commit  = 1'b1;
                        state_d = RX_IDLE;
                    end else begin
                        // Low stop bit: drop the byte and wait out the break
                        frame_set = 1'b1;
                        state_d   = RX_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            RX_BREAK: begin
                if (rxd_s) begin
                    state_d = RX_IDLE;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    // Holding register and sticky flags; a same-cycle pop frees the slot
    // for the incoming byte, and a same-cycle set beats the pop's clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_data_q      <= '0;
            rx_valid_q     <= 1'b0;
            rx_overrun_q   <= 1'b0;
            rx_frame_err_q <= 1'b0;
        end else begin
            if (commit) begin
                if (!rx_valid_q || bus.rx_pop) begin
                    rx_data_q <= shift_q;
                end
                rx_valid_q <= 1'b1;
            end else if (bus.rx_pop) begin
                rx_valid_q <= 1'b0;
            end

            if (commit && rx_valid_q && !bus.rx_pop) begin
                rx_overrun_q <= 1'b1;
            end else if (bus.rx_pop) begin
                rx_overrun_q <= 1'b0;
            end

            if (frame_set) begin
                rx_frame_err_q <= 1'b1;
            end else if (bus.rx_pop) begin
                rx_frame_err_q <= 1'b0;
            end
        end
    end

    assign bus.rx_data      = rx_data_q;
    assign bus.rx_valid     = rx_valid_q;
    assign bus.rx_overrun   = rx_overrun_q;
    assign bus.rx_frame_err = rx_frame_err_q;
    assign bus.rx_busy      = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit.
module tb_uart_rx;

    localparam int C = 16;
    // Fall of start bit to rx_valid high, in clock edges
    localparam int LATENCY = 2 + C / 2 + 9 * C + 1;

    logic clk = 1'b0;
    logic reset;
    logic serial_rxd;
    int   checks = 0;
    int   errors = 0;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_rxd (serial_rxd),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    // Drive one frame starting at the next falling clock edge; line is left
    // at the stop-bit level on return.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        @(negedge clk);
        serial_rxd = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_rxd = b[i];
            repeat (C) @(negedge clk);
        end
        serial_rxd = stop;
        repeat (C) @(negedge clk);
    endtask

    task automatic pop;
        @(negedge clk);
        bus.rx_pop = 1'b1;
        @(negedge clk);
        bus.rx_pop = 1'b0;
    endtask

    task automatic test_reset;
        reset      = 1'b0;
        serial_rxd = 1'b1;
        bus.rx_pop = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %0h expected 0", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", bus.rx_overrun); end
        checks++; if (bus.rx_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.rx_frame_err); end
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.rx_busy); end
        reset = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_basic;
        int lat;
        lat = -1;
        fork
            send_frame(8'h55, 1'b1);
            begin
                @(negedge clk);
                for (int n = 1; n <= 400; n++) begin
                    @(posedge clk);
                    #1;
                    if (bus.rx_valid === 1'b1) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        repeat (4) @(negedge clk);
        checks++; if (lat != LATENCY) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", lat, LATENCY); end
        checks++; if (bus.rx_data !== 8'h55) begin errors++; $display("FAIL basic_data: got %0h expected 55", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", bus.rx_valid); end
        checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL basic_overrun: got %b expected 0", bus.rx_overrun); end
        checks++; if (bus.rx_frame_err !== 1'b0) begin errors++; $display("FAIL basic_frame_err: got %b expected 0", bus.rx_frame_err); end
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL basic_busy: got %b expected 0", bus.rx_busy); end
        pop();
    endtask

    task automatic test_back_to_back;
        send_frame(8'hA3, 1'b1);
        send_frame(8'h0F, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (bus.rx_data !== 8'hA3) begin errors++; $display("FAIL b2b_data: got %0h expected a3", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b expected 1", bus.rx_valid); end
        checks++; if (bus.rx_overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun: got %b expected 1", bus.rx_overrun); end
        checks++; if (bus.rx_frame_err !== 1'b0) begin errors++; $display("FAIL b2b_frame_err: got %b expected 0", bus.rx_frame_err); end
        pop();
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_pop_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL b2b_pop_overrun: got %b expected 0", bus.rx_overrun); end
        checks++; if (bus.rx_data !== 8'hA3) begin errors++; $display("FAIL b2b_pop_data: got %0h expected a3", bus.rx_data); end
    endtask

    task automatic test_glitch;
        logic seen;
        seen = 1'b0;
        @(negedge clk);
        serial_rxd = 1'b0;
        repeat (4) @(negedge clk);
        serial_rxd = 1'b1;
        for (int n = 0; n < 3 * C; n++) begin
            @(negedge clk);
            if (bus.rx_busy === 1'b1) seen = 1'b1;
        end
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL glitch_busy_pulse: got %b expected 1", seen); end
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_end: got %b expected 0", bus.rx_busy); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.rx_frame_err !== 1'b0) begin errors++; $display("FAIL glitch_frame_err: got %b expected 0", bus.rx_frame_err); end
        checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL glitch_overrun: got %b expected 0", bus.rx_overrun); end
    endtask

    task automatic test_frame_err;
        send_frame(8'hFF, 1'b0);
        repeat (40 - C) @(negedge clk);
        checks++; if (bus.rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_flag: got %b expected 1", bus.rx_frame_err); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.rx_busy !== 1'b1) begin errors++; $display("FAIL ferr_busy_low_line: got %b expected 1", bus.rx_busy); end
        checks++; if (bus.rx_data !== 8'hA3) begin errors++; $display("FAIL ferr_data_kept: got %0h expected a3", bus.rx_data); end
        serial_rxd = 1'b1;
        repeat (5) @(negedge clk);
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL ferr_busy_release: got %b expected 0", bus.rx_busy); end
        checks++; if (bus.rx_frame_err !== 1'b1) begin errors++; $display("FAIL ferr_sticky: got %b expected 1", bus.rx_frame_err); end
        pop();
        checks++; if (bus.rx_frame_err !== 1'b0) begin errors++; $display("FAIL ferr_pop_clear: got %b expected 0", bus.rx_frame_err); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] b;
        b = 8'h3C;
        @(negedge clk);
        serial_rxd = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            serial_rxd = b[i];
            repeat (C) @(negedge clk);
        end
        serial_rxd = b[4];
        repeat (C / 2) @(negedge clk);
        checks++; if (bus.rx_busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b expected 1", bus.rx_busy); end
        reset = 1'b0;
        #1;
        checks++; if (bus.rx_data !== 8'h00) begin errors++; $display("FAIL mid_reset_data: got %0h expected 0", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b expected 0", bus.rx_valid); end
        checks++; if (bus.rx_busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", bus.rx_busy); end
        checks++; if (bus.rx_overrun !== 1'b0 || bus.rx_frame_err !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got %b%b expected 00", bus.rx_overrun, bus.rx_frame_err); end
        repeat (3) @(negedge clk);
        serial_rxd = 1'b1;
        reset = 1'b1;
        repeat (2 * C) @(negedge clk);
        send_frame(8'h3C, 1'b1);
        repeat (4) @(negedge clk);
        checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL mid_resend_data: got %0h expected 3c", bus.rx_data); end
        checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL mid_resend_valid: got %b expected 1", bus.rx_valid); end
        checks++; if (bus.rx_overrun !== 1'b0 || bus.rx_frame_err !== 1'b0) begin errors++; $display("FAIL mid_resend_flags: got %b%b expected 00", bus.rx_overrun, bus.rx_frame_err); end
        pop();
    endtask

    task automatic test_commit_pop;
        send_frame(8'h42, 1'b1);
        checks++; if (bus.rx_data !== 8'h42 || bus.rx_valid !== 1'b1) begin errors++; $display("FAIL cp_first: got %0h/%b expected 42/1", bus.rx_data, bus.rx_valid); end
        fork
            send_frame(8'h81, 1'b1);
            begin
                @(negedge clk);
                repeat (LATENCY - 1) @(posedge clk);
                @(negedge clk);
                bus.rx_pop = 1'b1;
                @(negedge clk);
                bus.rx_pop = 1'b0;
                checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL cp_valid: got %b expected 1", bus.rx_valid); end
                checks++; if (bus.rx_data !== 8'h81) begin errors++; $display("FAIL cp_data: got %0h expected 81", bus.rx_data); end
                checks++; if (bus.rx_overrun !== 1'b0) begin errors++; $display("FAIL cp_overrun: got %b expected 0", bus.rx_overrun); end
            end
        join
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_reset_mid_frame();
        test_commit_pop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
